// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the serial instruction-memory loader.
// Holds the frame FSM encoding, the UART receiver encoding and the baud helper.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  function automatic int calc_clks_per_bit(input int clk_freq_hz, input int baud);
    return clk_freq_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting start check.
// Emits a one-cycle byte_valid with byte_data and frame_err (stop bit sampled low).
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output rx_state_e  dbg_state
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rx_fall, half_done, bit_done;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall   = rx_prev_q & ~rx_sync_q;
  assign half_done = (cnt_q == CNT_W'(HALF - 1));
  assign bit_done  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
    case (state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (half_done) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (bit_done) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          ferr_d  = ~rx_sync_q;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;
  assign dbg_state  = state_q;

endmodule

// File: rtl/imem_loader.sv
// Frame parser that loads a checksummed program image from UART into instruction memory.
// Holds the core in reset until a complete, checksum-valid image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              loading,
  output logic              done,
  output logic              err,
  output logic [4:0]        dbg_state
);

  localparam int          CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int          DEPTH        = 2 ** ADDR_W;
  localparam logic [16:0] DEPTH_L      = 17'(DEPTH);

  // Receiver handshake: byte_valid is a one-cycle pulse with no back-pressure;
  // byte_data and frame_err are only meaningful in that cycle.
  logic       byte_valid, frame_err;
  logic [7:0] byte_data;
  rx_state_e  rx_dbg;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err),
    .dbg_state (rx_dbg)
  );

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        xor_q, xor_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [16:0]       len_full;
  logic              in_frame, good_byte;

  assign len_full  = {1'b0, byte_data, len_lo_q};
  assign in_frame  = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                     (state_q == ST_DATA)   || (state_q == ST_CSUM);
  assign good_byte = byte_valid && !frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Framing errors abort an open frame but are silently dropped outside one.
  always_comb begin
    state_d = state_q;
    if (byte_valid && frame_err) begin
      if (in_frame) state_d = ST_ERR;
    end else if (byte_valid) begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: if (byte_data == SYNC_BYTE) state_d = ST_LEN_LO;
        ST_LEN_LO: state_d = ST_LEN_HI;
        ST_LEN_HI: begin
          if (len_full > DEPTH_L)   state_d = ST_ERR;
          else if (len_full == '0)  state_d = ST_CSUM;
          else                      state_d = ST_DATA;
        end
        ST_DATA: begin
          if (byte_idx_q == 2'd3 && word_idx_q == len_q - 16'd1) state_d = ST_CSUM;
        end
        ST_CSUM: state_d = (byte_data == xor_q) ? ST_DONE : ST_ERR;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    xor_d      = xor_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (good_byte) begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (byte_data == SYNC_BYTE) begin
            word_idx_d = '0;
            byte_idx_d = '0;
            xor_d      = 8'h00;
          end
        end
        ST_LEN_LO: len_lo_d = byte_data;
        ST_LEN_HI: len_d    = {byte_data, len_lo_q};
        ST_DATA: begin
          xor_d      = xor_q ^ byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: asm_d[7:0]   = byte_data;
            2'd1: asm_d[15:8]  = byte_data;
            2'd2: asm_d[23:16] = byte_data;
            default: begin
              we_d       = 1'b1;
              waddr_d    = word_idx_q[ADDR_W-1:0];
              wdata_d    = {byte_data, asm_q};
              word_idx_d = word_idx_q + 16'd1;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo_q   <= 8'h00;
      len_q      <= 16'h0000;
      word_idx_q <= 16'h0000;
      byte_idx_q <= 2'd0;
      asm_q      <= 24'h000000;
      xor_q      <= 8'h00;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'h0;
    end else begin
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      xor_q      <= xor_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    loading   = in_frame;
    done      = (state_q == ST_DONE);
    err       = (state_q == ST_ERR);
    cpu_rst_n = (state_q == ST_DONE);
  end

  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign dbg_state  = {rx_dbg, state_q};

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: serial frames driven bit by bit,
// writes and final status compared against a frame-level reference model.
module tb_imem_loader;

  localparam int CLK_FREQ_HZ = 2_400_000;
  localparam int BAUD        = 100_000;
  localparam int ADDR_W      = 8;
  localparam int CPB         = CLK_FREQ_HZ / BAUD;
  localparam int DEPTH       = 2 ** ADDR_W;
  localparam int W           = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx = 1'b1;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n, loading, done, err;
  logic [4:0]        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]  exp_q[$];
  logic [7:0]    frame_q[$];
  logic [31:0]   words_q[$];
  logic          exp_done, exp_err;

  imem_loader #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD       (BAUD),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .imem_we   (imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .loading   (loading),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: every write strobe must match the next expected {addr, data}
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%08h, required no write", imem_waddr, imem_wdata);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({imem_waddr, imem_wdata} !== e) begin
          n_fail++;
          $display("FAIL write: got addr=%0d data=%08h, required addr=%0d data=%08h",
                   imem_waddr, imem_wdata, e[W-1:32], e[31:0]);
        end
      end
    end
  end

  // the core may only be released while the last image is marked done
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (cpu_rst_n !== done) begin
        n_fail++;
        $display("FAIL cpu_rst_vs_done: cpu_rst_n=%b done=%b, required equal", cpu_rst_n, done);
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_range(input int first, input int last, input int ferr_idx);
    for (int i = first; i <= last; i++) send_byte(frame_q[i], 1'(i != ferr_idx));
  endtask

  task automatic build_frame(input bit good);
    logic [7:0]  cs;
    logic [15:0] n;
    cs = 8'h00;
    n  = 16'(words_q.size());
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    foreach (words_q[w]) begin
      for (int k = 0; k < 4; k++) begin
        frame_q.push_back(words_q[w][8*k +: 8]);
        cs ^= words_q[w][8*k +: 8];
      end
    end
    frame_q.push_back(good ? cs : ~cs);
  endtask

  // reference model: parse frame_q by the frame rules, truncated at a framing error
  task automatic model_frame(input int ferr_idx);
    int          n;
    logic [7:0]  cs;
    logic [31:0] w;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = int'({frame_q[2], frame_q[1]});
    if (n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (ferr_idx >= 0 && ferr_idx <= 6 + 4*i) begin
        exp_err = 1'b1;
        return;
      end
      w = {frame_q[6+4*i], frame_q[5+4*i], frame_q[4+4*i], frame_q[3+4*i]};
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      exp_q.push_back({ADDR_W'(i), w});
    end
    if (ferr_idx >= 0) begin
      exp_err = 1'b1;
      return;
    end
    exp_done = (frame_q[3+4*n] == cs);
    exp_err  = !exp_done;
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({imem_we, imem_waddr, imem_wdata, cpu_rst_n, loading, done, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b addr=%0d data=%08h crst=%b ld=%b dn=%b er=%b, required all 0",
               imem_we, imem_waddr, imem_wdata, cpu_rst_n, loading, done, err);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_normal();
    words_q = '{32'h00A00513, 32'h00500593};
    build_frame(1'b1);
    model_frame(-1);
    send_range(0, frame_q.size() - 2, -1);
    n_checks++;
    if ({loading, done, cpu_rst_n} !== 3'b100) begin
      n_fail++;
      $display("FAIL normal_before_csum: got ld/dn/crst=%b%b%b, required 100", loading, done, cpu_rst_n);
    end
    send_range(frame_q.size() - 1, frame_q.size() - 1, -1);
    n_checks++;
    if ({loading, done, err, cpu_rst_n} !== {1'b0, exp_done, exp_err, exp_done} || !exp_done) begin
      n_fail++;
      $display("FAIL normal_done: got ld/dn/er/crst=%b%b%b%b, required 0101", loading, done, err, cpu_rst_n);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL normal_writes: got %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_bad_csum();
    words_q = '{32'h00A00513, 32'h00500593};
    build_frame(1'b0);
    model_frame(-1);
    send_range(0, frame_q.size() - 1, -1);
    repeat (4) @(negedge clk);
    n_checks++;
    if ({loading, done, err, cpu_rst_n} !== {1'b0, exp_done, exp_err, 1'b0}) begin
      n_fail++;
      $display("FAIL bad_csum: got ld/dn/er/crst=%b%b%b%b, required 0010", loading, done, err, cpu_rst_n);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bad_csum_writes: got %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_oversize();
    frame_q = '{8'hA5, 8'h01, 8'h01};
    model_frame(-1);
    send_range(0, 2, -1);
    repeat (4) @(negedge clk);
    n_checks++;
    if ({loading, done, err} !== {1'b0, exp_done, exp_err}) begin
      n_fail++;
      $display("FAIL oversize: got ld/dn/er=%b%b%b, required 001", loading, done, err);
    end
  endtask

  task automatic test_framing();
    words_q = '{32'h00A00513, 32'h00500593};
    build_frame(1'b1);
    model_frame(5);
    send_range(0, 5, 5);
    repeat (4) @(negedge clk);
    n_checks++;
    if ({loading, done, err} !== {1'b0, exp_done, exp_err}) begin
      n_fail++;
      $display("FAIL framing_err: got ld/dn/er=%b%b%b, required 001", loading, done, err);
    end
    words_q = '{$urandom(), $urandom(), $urandom()};
    build_frame(1'b1);
    model_frame(-1);
    send_range(0, 0, -1);
    n_checks++;
    if ({loading, err} !== 2'b10) begin
      n_fail++;
      $display("FAIL framing_sync_clears: got ld/er=%b%b, required 10", loading, err);
    end
    send_range(1, frame_q.size() - 1, -1);
    repeat (4) @(negedge clk);
    n_checks++;
    if ({done, err, cpu_rst_n} !== {exp_done, exp_err, exp_done} || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL framing_recover: got dn/er/crst=%b%b%b pending=%0d, required 101 pending=0",
               done, err, cpu_rst_n, exp_q.size());
    end
  endtask

  task automatic test_empty_reload();
    words_q.delete();
    build_frame(1'b1);
    model_frame(-1);
    send_range(0, frame_q.size() - 1, -1);
    repeat (4) @(negedge clk);
    n_checks++;
    if ({done, err, cpu_rst_n} !== {exp_done, exp_err, exp_done} || !exp_done) begin
      n_fail++;
      $display("FAIL empty_frame: got dn/er/crst=%b%b%b, required 101", done, err, cpu_rst_n);
    end
    words_q = '{32'h12345678, 32'hDEADBEEF};
    build_frame(1'b1);
    model_frame(-1);
    send_range(0, 0, -1);
    n_checks++;
    if ({loading, done, cpu_rst_n} !== 3'b100) begin
      n_fail++;
      $display("FAIL reload_sync: got ld/dn/crst=%b%b%b, required 100", loading, done, cpu_rst_n);
    end
    send_range(1, frame_q.size() - 1, -1);
    repeat (4) @(negedge clk);
    n_checks++;
    if ({done, err, cpu_rst_n} !== 3'b101 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reload_done: got dn/er/crst=%b%b%b pending=%0d, required 101 pending=0",
               done, err, cpu_rst_n, exp_q.size());
    end
  endtask

  task automatic test_glitch();
    words_q = '{32'hCAFEF00D};
    build_frame(1'b1);
    model_frame(-1);
    send_range(0, 0, -1);
    rx = 1'b0;
    repeat (CPB/2 - 3) @(negedge clk);
    rx = 1'b1;
    repeat (2*CPB) @(negedge clk);
    n_checks++;
    if ({loading, err} !== 2'b10) begin
      n_fail++;
      $display("FAIL glitch_ignored: got ld/er=%b%b, required 10", loading, err);
    end
    send_range(1, frame_q.size() - 1, -1);
    repeat (4) @(negedge clk);
    n_checks++;
    if ({done, err} !== 2'b10 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL glitch_frame: got dn/er=%b%b pending=%0d, required 10 pending=0", done, err, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    words_q = '{32'h00A00513, 32'h00500593};
    build_frame(1'b1);
    model_frame(-1);
    send_range(0, 4, -1);
    rx = 1'b0;
    repeat (3*CPB) @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if ({imem_we, imem_waddr, imem_wdata, cpu_rst_n, loading, done, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got we=%b addr=%0d data=%08h crst=%b ld=%b dn=%b er=%b, required all 0",
               imem_we, imem_waddr, imem_wdata, cpu_rst_n, loading, done, err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2*CPB) @(negedge clk);
    words_q = '{$urandom(), $urandom()};
    build_frame(1'b1);
    model_frame(-1);
    send_range(0, frame_q.size() - 1, -1);
    repeat (4) @(negedge clk);
    n_checks++;
    if ({done, err, cpu_rst_n} !== 3'b101 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_recover: got dn/er/crst=%b%b%b pending=%0d, required 101 pending=0",
               done, err, cpu_rst_n, exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      int n;
      n = $urandom_range(1, 3);
      words_q.delete();
      if (f == 0) words_q.push_back(32'hA5A500A5);
      while (words_q.size() < n) words_q.push_back($urandom());
      build_frame(1'($urandom_range(0, 3) != 0));
      model_frame(-1);
      send_range(0, frame_q.size() - 1, -1);
      repeat (4) @(negedge clk);
      n_checks++;
      if ({loading, done, err, cpu_rst_n} !== {1'b0, exp_done, exp_err, exp_done}) begin
        n_fail++;
        $display("FAIL random_frame%0d: got ld/dn/er/crst=%b%b%b%b, required 0%b%b%b",
                 f, loading, done, err, cpu_rst_n, exp_done, exp_err, exp_done);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL random_writes%0d: got %0d writes missing, required 0", f, exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_csum();
    test_oversize();
    test_framing();
    test_empty_reload();
    test_glitch();
    test_reset_mid();
    test_random();
    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
